snn_layer_sched: RTL and testbench
==================================

// Module: snn_layer_sched
// PURPOSE
//  Sequences one fully-connected spiking layer of the snn core over a run of timesteps.
//  Per timestep it latches the input spike vector, walks its set bits, and reads the weights of each active input.
//  It directs every weight into the addressed neuron's accumulator, then fires one leak/threshold update.
//  It sits between the host control regs, the weight SRAM read port and the neuron datapath.
// PARAMETERS
//  N_INPUTS   64  input spike lines per timestep
//  N_NEURONS  16  neurons in the layer
//  ADDR_W     10  weight address width; must be >= clog2(N_INPUTS*N_NEURONS)
//  STEP_W      8  width of timestep count
// PORTS
//  clock         in   1          single clock, all logic on posedge
//  rst           in   1          synchronous, active-high reset
//  start         in   1          pulse: begin run; ignored while busy
//  num_steps     in   STEP_W     timesteps to run; sampled on accepted start
//  in_req        out  1          request next input spike vector
//  in_ack        in   1          in_spikes valid this cycle
//  in_spikes     in   N_INPUTS   spike vector for current timestep
//  w_req         out  1          weight read request
//  w_addr        out  ADDR_W     weight address = in_idx*N_NEURONS + nrn_idx
//  w_ack         in   1          weight data valid on SRAM bus this cycle
//  nrn_acc       out  1          datapath: add weight bus into neuron nrn_idx
//  nrn_idx       out  clog2(N_NEURONS)  target neuron
//  nrn_update    out  1          1-cycle pulse: leak/threshold/fire all neurons
//  step_idx      out  STEP_W     current timestep (0-based)
//  busy          out  1          high from accepted start until done
//  done          out  1          1-cycle pulse at end of run
// BEHAVIOUR
//  Reset: all outputs 0, FSM IDLE, internal vectors/counters cleared. Reset mid-run aborts without done.
//  FSM: IDLE -> FETCH -> SCAN -> READ -> (SCAN | UPDATE) -> (FETCH | FIN) -> IDLE.
//  IDLE: on start, latch num_steps, step_idx=0, busy=1; if num_steps==0 go FIN (no requests issued).
//  FETCH: in_req held high until in_ack; on in_ack latch in_spikes, in_idx=0 -> SCAN.
//  SCAN: examines bit in_idx, one bit per cycle; set -> READ with nrn_idx=0.
//   Clear -> in_idx++; past N_INPUTS-1 -> UPDATE.
//  READ: w_req high, w_addr stable until w_ack; ack may coincide with first req cycle.
//   nrn_acc asserted in exactly the w_ack cycle; nrn_idx++ next cycle, w_req stays high.
//   After nrn_idx N_NEURONS-1 acked: clear the spike bit, in_idx++, -> SCAN (or UPDATE if last).
//  UPDATE: nrn_update high one cycle; step_idx++; if new step_idx==num_steps -> FIN else FETCH.
//  FIN: done=1 one cycle, busy=0 same cycle -> IDLE. New start accepted the following cycle.
//  w_addr arithmetic unsigned, no wrap within legal params; nrn_acc never asserted without w_ack.
//  All-zero spike vector: N_INPUTS SCAN cycles, no w_req, then UPDATE.
//  in_ack/w_ack outside their wait states are ignored.
// CONFIGURATION
//  SNN_SCHED_PERF_EN defined: adds output perf_cycles[31:0] and perf_reads[31:0].
//   perf_cycles counts busy cycles; perf_reads counts w_ack-accepted reads.
//   Both clear on accepted start and hold after done.
//  Undefined: ports absent, no counters synthesised; all other behaviour identical.
// STRUCTURE
//  snn_pkg: FSM state encoding localparams (S_IDLE..S_FIN), default N_INPUTS/N_NEURONS.
//   snn_pkg also holds a CLOG2 helper function.
//  One sub-module: snn_sched_perf (the optional counters), instantiated only under SNN_SCHED_PERF_EN.
//  Spike scan, address generation and FSM stay in snn_layer_sched.
// TESTING
//  1 num_steps=0, start -> done pulse 2 cycles after start; in_req/w_req never high.
//  2 N_INPUTS=64,N_NEURONS=16, 1 step, in_spikes bit 3 only, w_ack tied 1:
//    -> 16 nrn_acc, w_addr 48..63, then one nrn_update, done.
//  3 bits 0 and 63 set, w_ack delayed 2 cycles each read:
//    -> w_addr stable while waiting; addrs 0..15 then 1008..1023; nrn_acc count 32.
//  4 num_steps=3, all-zero spikes -> 3 in_req handshakes, 3 nrn_update, step_idx 0,1,2, no w_req.
//  5 rst asserted mid READ -> next cycle all outputs 0, busy=0, no done.
//    New start then runs cleanly from step 0.
//  6 start pulsed while busy -> ignored, run completes unchanged.
//    With SNN_SCHED_PERF_EN, perf_reads equals nrn_acc count.

Source files
------------

// File: rtl/snn_pkg.sv
// Shared definitions for the spiking-layer scheduler:
// FSM state encoding, default layer sizes and a clog2 helper.
package snn_pkg;

  localparam int N_INPUTS_DEF  = 64;
  localparam int N_NEURONS_DEF = 16;

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_SCAN,
    S_READ,
    S_UPDATE,
    S_FIN
  } sched_state_e;

  function automatic int CLOG2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r++;
    return (r < 1) ? 1 : r;
  endfunction

endpackage

// File: rtl/snn_layer_sched_if.sv
// Host / weight-SRAM / neuron-datapath bundle of the layer scheduler.
// slave = scheduler side, master = surrounding system side.
interface snn_layer_sched_if
  import snn_pkg::*;
#(
  parameter int N_INPUTS  = N_INPUTS_DEF,
  parameter int N_NEURONS = N_NEURONS_DEF,
  parameter int ADDR_W    = 10,
  parameter int STEP_W    = 8
);
  localparam int NRN_W = CLOG2(N_NEURONS);

  logic                start;
  logic [STEP_W-1:0]   num_steps;
  logic                in_req;
  logic                in_ack;
  logic [N_INPUTS-1:0] in_spikes;
  logic                w_req;
  logic [ADDR_W-1:0]   w_addr;
  logic                w_ack;
  logic                nrn_acc;
  logic [NRN_W-1:0]    nrn_idx;
  logic                nrn_update;
  logic [STEP_W-1:0]   step_idx;
  logic                busy;
  logic                done;

  modport slave (
    input  start, num_steps, in_ack, in_spikes, w_ack,
    output in_req, w_req, w_addr, nrn_acc, nrn_idx,
    output nrn_update, step_idx, busy, done
  );

  modport master (
    output start, num_steps, in_ack, in_spikes, w_ack,
    input  in_req, w_req, w_addr, nrn_acc, nrn_idx,
    input  nrn_update, step_idx, busy, done
  );

endinterface

// File: rtl/snn_sched_perf.sv
// Optional busy-cycle and weight-read counters for the layer scheduler,
// present only when SNN_SCHED_PERF_EN is defined.
module snn_sched_perf
  import snn_pkg::*;
(
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        clr_i,
  input  logic        busy_i,
  input  logic        read_i,
  output logic [31:0] cycles_o,
  output logic [31:0] reads_o
);
  logic [31:0] cycles_q;
  logic [31:0] reads_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cycles_q <= '0;
      reads_q  <= '0;
    end else if (clr_i) begin
      cycles_q <= '0;
      reads_q  <= '0;
    end else begin
      if (busy_i) cycles_q <= cycles_q + 32'd1;
      if (read_i) reads_q  <= reads_q + 32'd1;
    end
  end

  assign cycles_o = cycles_q;
  assign reads_o  = reads_q;

endmodule

// File: rtl/snn_layer_sched.sv
// Timestep sequencer for one fully-connected spiking layer.
// Optional perf counters: define SNN_SCHED_PERF_EN.
module snn_layer_sched
  import snn_pkg::*;
#(
  parameter int N_INPUTS  = N_INPUTS_DEF,
  parameter int N_NEURONS = N_NEURONS_DEF,
  parameter int ADDR_W    = 10,
  parameter int STEP_W    = 8
) (
  input  logic clock,
  input  logic rst,
  snn_layer_sched_if.slave bus
`ifdef SNN_SCHED_PERF_EN
  ,
  output logic [31:0] perf_cycles,
  output logic [31:0] perf_reads
`endif
);
  localparam int IDX_W = CLOG2(N_INPUTS);
  localparam int NRN_W = CLOG2(N_NEURONS);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(N_INPUTS - 1);
  localparam logic [NRN_W-1:0] NRN_LAST = NRN_W'(N_NEURONS - 1);

  sched_state_e        state_q;
  logic [N_INPUTS-1:0] spikes_q;
  logic [IDX_W-1:0]    in_idx_q;
  logic [NRN_W-1:0]    nrn_idx_q;
  logic [STEP_W-1:0]   steps_q;
  logic [STEP_W-1:0]   step_idx_q;
  logic [STEP_W-1:0]   step_idx_d;
  logic                busy_q;
  logic                done_q;
  logic                in_req_q;
  logic                w_req_q;
  logic                upd_q;
  logic                start_ok;
  logic                last_in;
  logic                nrn_acc;

  // a start in the done cycle is held off until the next one
  assign start_ok   = (state_q == S_IDLE) && bus.start && !done_q;
  assign last_in    = (in_idx_q == IDX_LAST);
  assign step_idx_d = step_idx_q + STEP_W'(1);
  assign nrn_acc    = w_req_q && bus.w_ack;

  always_ff @(posedge clock) begin
    if (rst) begin
      state_q    <= S_IDLE;
      spikes_q   <= '0;
      in_idx_q   <= '0;
      nrn_idx_q  <= '0;
      steps_q    <= '0;
      step_idx_q <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      in_req_q   <= 1'b0;
      w_req_q    <= 1'b0;
      upd_q      <= 1'b0;
    end else begin
      done_q <= 1'b0;
      upd_q  <= 1'b0;
      unique case (state_q)
        S_IDLE: begin
          if (start_ok) begin
            steps_q    <= bus.num_steps;
            step_idx_q <= '0;
            busy_q     <= 1'b1;
            if (bus.num_steps == '0) begin
              state_q <= S_FIN;
            end else begin
              state_q  <= S_FETCH;
              in_req_q <= 1'b1;
            end
          end
        end
        S_FETCH: begin
          if (bus.in_ack) begin
            spikes_q <= bus.in_spikes;
            in_idx_q <= '0;
            in_req_q <= 1'b0;
            state_q  <= S_SCAN;
          end
        end
        S_SCAN: begin
          if (spikes_q[in_idx_q]) begin
            nrn_idx_q <= '0;
            w_req_q   <= 1'b1;
            state_q   <= S_READ;
          end else if (last_in) begin
            upd_q   <= 1'b1;
            state_q <= S_UPDATE;
          end else begin
            in_idx_q <= in_idx_q + IDX_W'(1);
          end
        end
        S_READ: begin
          if (bus.w_ack) begin
            if (nrn_idx_q == NRN_LAST) begin
              w_req_q            <= 1'b0;
              spikes_q[in_idx_q] <= 1'b0;
              if (last_in) begin
                upd_q   <= 1'b1;
                state_q <= S_UPDATE;
              end else begin
                in_idx_q <= in_idx_q + IDX_W'(1);
                state_q  <= S_SCAN;
              end
            end else begin
              nrn_idx_q <= nrn_idx_q + NRN_W'(1);
            end
          end
        end
        S_UPDATE: begin
          step_idx_q <= step_idx_d;
          if (step_idx_d == steps_q) begin
            state_q <= S_FIN;
          end else begin
            state_q  <= S_FETCH;
            in_req_q <= 1'b1;
          end
        end
        S_FIN: begin
          done_q  <= 1'b1;
          busy_q  <= 1'b0;
          state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign bus.in_req     = in_req_q;
  assign bus.w_req      = w_req_q;
  assign bus.w_addr     = ADDR_W'(in_idx_q) * ADDR_W'(N_NEURONS)
                        + ADDR_W'(nrn_idx_q);
  assign bus.nrn_acc    = nrn_acc;
  assign bus.nrn_idx    = nrn_idx_q;
  assign bus.nrn_update = upd_q;
  assign bus.step_idx   = step_idx_q;
  assign bus.busy       = busy_q;
  assign bus.done       = done_q;

`ifdef SNN_SCHED_PERF_EN
  snn_sched_perf u_perf (
    .clk_i    (clock),
    .rst_i    (rst),
    .clr_i    (start_ok),
    .busy_i   (busy_q),
    .read_i   (nrn_acc),
    .cycles_o (perf_cycles),
    .reads_o  (perf_reads)
  );
`endif

endmodule

// File: tb/tb_snn_layer_sched.sv
// Self-checking bench for snn_layer_sched: vector table, corner
// sequences and randomized runs against an event-level model.
module tb_snn_layer_sched;
  localparam int NI = 64;
  localparam int NN = 16;
  localparam int AW = 10;
  localparam int SW = 8;

  logic clock = 1'b0;
  logic rst;
  always #5 clock = ~clock;

  snn_layer_sched_if #(
    .N_INPUTS(NI), .N_NEURONS(NN), .ADDR_W(AW), .STEP_W(SW)
  ) bus ();

`ifdef SNN_SCHED_PERF_EN
  logic [31:0] perf_cycles;
  logic [31:0] perf_reads;
`endif

  snn_layer_sched #(
    .N_INPUTS(NI), .N_NEURONS(NN), .ADDR_W(AW), .STEP_W(SW)
  ) dut (
    .clock (clock),
    .rst   (rst),
    .bus   (bus)
`ifdef SNN_SCHED_PERF_EN
    ,
    .perf_cycles (perf_cycles),
    .perf_reads  (perf_reads)
`endif
  );

  int n_vec = 0;
  int n_bad = 0;
  int ack_mode = 0;
  bit noise = 1'b0;

  logic [NI-1:0] vec_q[$];
  int exp_addr_q[$];
  int rd_addr_q[$];
  int rd_nrn_q[$];
  int upd_q[$];
  int hs_cnt = 0, done_cnt = 0, wreq_cnt = 0, inreq_cnt = 0;
  int busy_cnt = 0, unstable = 0, acc_bad = 0;
  logic pw_req = 1'b0, pw_ack = 1'b0;
  logic [AW-1:0] pw_addr = '0;
  int w_wait = 0, w_dly = 0, i_wait = 0, i_dly = 0;

  function automatic int pick_dly();
    if (ack_mode == 0) return 0;
    if (ack_mode == 1) return 2;
    return int'($urandom_range(0, 2));
  endfunction

  // environment responder: SRAM and spike source
  always @(negedge clock) begin
    if (bus.w_req) begin
      if (w_wait >= w_dly) begin
        bus.w_ack = 1'b1;
        w_wait = 0;
        w_dly = pick_dly();
      end else begin
        bus.w_ack = 1'b0;
        w_wait++;
      end
    end else begin
      if (ack_mode == 0) bus.w_ack = 1'b1;
      else bus.w_ack = noise ? 1'($urandom_range(0, 1)) : 1'b0;
      w_wait = 0;
      w_dly = pick_dly();
    end
    if (bus.in_req) begin
      if (i_wait >= i_dly) begin
        bus.in_ack = 1'b1;
        if (vec_q.size() > 0) bus.in_spikes = vec_q.pop_front();
        else bus.in_spikes = '0;
        i_wait = 0;
        i_dly = int'($urandom_range(0, 2));
      end else begin
        bus.in_ack = 1'b0;
        i_wait++;
      end
    end else begin
      bus.in_ack = noise ? 1'($urandom_range(0, 1)) : 1'b0;
      bus.in_spikes = noise ? {$urandom, $urandom} : '0;
      i_wait = 0;
    end
  end

  // event monitor, sampled just before each rising edge
  always @(negedge clock) begin
    #4;
    if (bus.nrn_acc) begin
      rd_addr_q.push_back(int'(bus.w_addr));
      rd_nrn_q.push_back(int'(bus.nrn_idx));
    end
    if (bus.nrn_acc && !bus.w_ack) acc_bad++;
    if (bus.nrn_update) upd_q.push_back(int'(bus.step_idx));
    if (bus.in_req && bus.in_ack) hs_cnt++;
    if (bus.w_req) wreq_cnt++;
    if (bus.in_req) inreq_cnt++;
    if (bus.busy) busy_cnt++;
    if (bus.done) done_cnt++;
    if (pw_req && !pw_ack && bus.w_req && bus.w_addr != pw_addr)
      unstable++;
    pw_req = bus.w_req;
    pw_ack = bus.w_ack;
    pw_addr = bus.w_addr;
  end

  task automatic check(input string nm, input longint act,
                       input longint exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic clear_mon();
    rd_addr_q.delete();
    rd_nrn_q.delete();
    upd_q.delete();
    hs_cnt = 0; done_cnt = 0; wreq_cnt = 0; inreq_cnt = 0;
    busy_cnt = 0; unstable = 0; acc_bad = 0;
  endtask

  // model: every set input, ascending, reads all neurons in order
  task automatic add_step(input logic [NI-1:0] v);
    vec_q.push_back(v);
    for (int i = 0; i < NI; i++)
      if (v[i])
        for (int n = 0; n < NN; n++) exp_addr_q.push_back(i * NN + n);
  endtask

  task automatic reset_dut();
    rst = 1'b1;
    @(negedge clock);
    @(negedge clock);
    rst = 1'b0;
    vec_q.delete();
    exp_addr_q.delete();
  endtask

  task automatic run(input int steps);
    bit ok;
    ok = 1'b0;
    @(negedge clock);
    clear_mon();
    bus.num_steps = SW'(steps);
    bus.start = 1'b1;
    @(negedge clock);
    bus.start = 1'b0;
    for (int c = 0; c < 40000 && !ok; c++) begin
      @(negedge clock);
      if (done_cnt > 0) ok = 1'b1;
    end
    if (!ok) begin
      check("run_timeout", 0, 1);
      reset_dut();
    end
    repeat (3) @(negedge clock);
  endtask

  task automatic model_check(input int steps);
    int errs;
    errs = 0;
    check("reads", rd_addr_q.size(), exp_addr_q.size());
    for (int k = 0; k < rd_addr_q.size() && k < exp_addr_q.size(); k++)
      if (rd_addr_q[k] != exp_addr_q[k] || rd_nrn_q[k] != exp_addr_q[k] % NN)
        errs++;
    check("rd_seq_errs", errs, 0);
    check("updates", upd_q.size(), steps);
    errs = 0;
    foreach (upd_q[k]) if (upd_q[k] != k) errs++;
    check("step_idx_errs", errs, 0);
    check("in_handshakes", hs_cnt, steps);
    check("done_pulses", done_cnt, 1);
    check("addr_unstable", unstable, 0);
    check("acc_without_ack", acc_bad, 0);
`ifdef SNN_SCHED_PERF_EN
    check("perf_reads", perf_reads, rd_addr_q.size());
    check("perf_cycles", perf_cycles, busy_cnt);
`endif
    exp_addr_q.delete();
  endtask

  typedef struct {
    int            steps;
    logic [NI-1:0] spk;
    int            mode;
    int            reads;
    int            upd;
    int            first;
    int            last;
  } vec_t;

  vec_t tbl[6];

  initial begin
    int lat;
    bit got;
    logic [NI-1:0] v;
    int steps;

    tbl[0] = '{0, 64'h0, 0, 0, 0, 0, 0};
    tbl[1] = '{1, 64'h8, 0, 16, 1, 48, 63};
    tbl[2] = '{1, 64'h8000_0000_0000_0001, 1, 32, 1, 0, 1023};
    tbl[3] = '{3, 64'h0, 2, 0, 3, 0, 0};
    tbl[4] = '{2, 64'h420, 0, 64, 2, 80, 175};
    tbl[5] = '{1, {NI{1'b1}}, 0, 1024, 1, 0, 1023};

    rst = 1'b1;
    bus.start = 1'b0;
    bus.num_steps = '0;
    bus.in_ack = 1'b0;
    bus.in_spikes = '0;
    bus.w_ack = 1'b0;
    repeat (3) @(negedge clock);
    check("rst_flags", {bus.busy, bus.done, bus.in_req, bus.w_req,
                        bus.nrn_acc, bus.nrn_update}, 0);
    check("rst_step_idx", bus.step_idx, 0);
    check("rst_w_addr", bus.w_addr, 0);
    rst = 1'b0;

    foreach (tbl[t]) begin
      ack_mode = tbl[t].mode;
      noise = (tbl[t].mode == 2);
      for (int s = 0; s < tbl[t].steps; s++) add_step(tbl[t].spk);
      run(tbl[t].steps);
      check("tbl_reads", rd_addr_q.size(), tbl[t].reads);
      check("tbl_updates", upd_q.size(), tbl[t].upd);
      check("tbl_wreq_seen", wreq_cnt > 0, tbl[t].reads > 0);
      check("tbl_inreq_seen", inreq_cnt > 0, tbl[t].steps > 0);
      if (tbl[t].reads > 0) begin
        check("tbl_first_addr", rd_addr_q[0], tbl[t].first);
        check("tbl_last_addr", rd_addr_q[rd_addr_q.size()-1], tbl[t].last);
      end
      model_check(tbl[t].steps);
    end

    // zero-step run: done two cycles after the start edge
    ack_mode = 0;
    noise = 1'b0;
    @(negedge clock);
    clear_mon();
    bus.num_steps = '0;
    bus.start = 1'b1;
    lat = -1;
    for (int k = 1; k <= 6; k++) begin
      @(negedge clock);
      bus.start = 1'b0;
      if (bus.done && lat < 0) lat = k;
    end
    check("done_latency", lat, 2);
    check("zero_steps_inreq", inreq_cnt, 0);
    check("zero_steps_wreq", wreq_cnt, 0);

    // reset while a weight read is pending
    ack_mode = 1;
    add_step(64'h200);
    @(negedge clock);
    clear_mon();
    bus.num_steps = SW'(4);
    bus.start = 1'b1;
    @(negedge clock);
    bus.start = 1'b0;
    got = 1'b0;
    for (int c = 0; c < 200 && !got; c++) begin
      @(negedge clock);
      if (bus.w_req) got = 1'b1;
    end
    check("reached_read", got, 1);
    @(negedge clock);
    rst = 1'b1;
    @(negedge clock);
    check("abort_flags", {bus.busy, bus.done, bus.in_req, bus.w_req,
                          bus.nrn_acc, bus.nrn_update}, 0);
    check("abort_step_idx", bus.step_idx, 0);
    check("abort_w_addr", bus.w_addr, 0);
    check("abort_nrn_idx", bus.nrn_idx, 0);
    rst = 1'b0;
    vec_q.delete();
    exp_addr_q.delete();
    repeat (5) @(negedge clock);
    check("abort_no_done", done_cnt, 0);
    ack_mode = 2;
    noise = 1'b1;
    add_step(64'h0000_0000_0001_0080);
    add_step(64'h4000_0000_0000_0000);
    run(2);
    model_check(2);

    // start pulses during a run are ignored
    ack_mode = 0;
    noise = 1'b0;
    add_step(64'h4);
    @(negedge clock);
    clear_mon();
    bus.num_steps = SW'(1);
    bus.start = 1'b1;
    @(negedge clock);
    bus.start = 1'b0;
    got = 1'b0;
    for (int c = 0; c < 2000 && !got; c++) begin
      @(negedge clock);
      if (bus.done) begin
        got = 1'b1;
        bus.start = 1'b0;
      end else begin
        bus.start = bus.busy ? 1'($urandom_range(0, 1)) : 1'b0;
        bus.num_steps = SW'(5);
      end
    end
    bus.start = 1'b0;
    check("busy_run_done", got, 1);
    repeat (4) @(negedge clock);
    check("busy_after_run", bus.busy, 0);
    model_check(1);

    // randomized runs
    for (int r = 0; r < 6; r++) begin
      steps = int'($urandom_range(1, 3));
      ack_mode = int'($urandom_range(0, 2));
      noise = 1'($urandom_range(0, 1));
      for (int s = 0; s < steps; s++) begin
        for (int i = 0; i < NI; i++) v[i] = ($urandom_range(0, 7) == 0);
        add_step(v);
      end
      run(steps);
      model_check(steps);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
